// File: rtl/key_pkg.sv
// Shared constants for the pushbutton conditioner: key count and the
// bit layout of the 32-bit status word presented to the CPU.
package key_pkg;

    localparam int N_KEYS    = 4;
    localparam int PCNT_W    = 4;
    localparam int WORD_W    = 32;

    localparam int LEVEL_LSB = 0;
    localparam int FLAG_LSB  = 4;
    localparam int CNT_LSB   = 8;

    // Everything above the last press counter reads as zero.
    localparam int RSVD_LSB  = CNT_LSB + N_KEYS * PCNT_W;
    localparam int RSVD_W    = WORD_W - RSVD_LSB;

    // Bit position of a key's press counter inside the status word.
    function automatic int cnt_lsb(input int key);
        return CNT_LSB + key * PCNT_W;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, debounce counter with stable
// pressed level, and a registered one-cycle strobe per accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic stable,
    output logic press_event,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          pressed_raw;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        pressed_raw = ~sync2_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        press_event = 1'b0;

        // The count only advances while the synchronised level disagrees
        // with the accepted level; any agreement restarts it from zero.
        if (pressed_raw == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d    = pressed_raw;
            cnt_d       = '0;
            press_event = pressed_raw;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        pulse_d = press_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign stable      = stable_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the four active-low KEY buttons into the CPU status word:
// debounced levels, acknowledgeable sticky press flags and press counters.
module key_input_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_KEYS-1:0] ack,
    output logic [WORD_W-1:0] gpio_in,
    output logic [N_KEYS-1:0] press_pulse
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press_event;
    logic [N_KEYS-1:0] flag_q, flag_d;
    logic [PCNT_W-1:0] pcnt_q [N_KEYS];
    logic [PCNT_W-1:0] pcnt_d [N_KEYS];

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[g]),
            .stable     (level[g]),
            .press_event(press_event[g]),
            .press_pulse(press_pulse[g])
        );
    end

    // A press arriving together with its ack keeps the flag set so the
    // CPU never loses a press it has not yet seen.
    always_comb begin
        flag_d = press_event | (flag_q & ~ack);
        for (int i = 0; i < N_KEYS; i++) begin
            pcnt_d[i] = press_event[i] ? pcnt_q[i] + PCNT_W'(1) : pcnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                pcnt_q[i] <= '0;
            end
        end else begin
            flag_q <= flag_d;
            for (int i = 0; i < N_KEYS; i++) begin
                pcnt_q[i] <= pcnt_d[i];
            end
        end
    end

    // Every field comes straight from a flop; no path from key_n or ack.
    always_comb begin
        gpio_in                         = '0;
        gpio_in[LEVEL_LSB +: N_KEYS]    = level;
        gpio_in[FLAG_LSB  +: N_KEYS]    = flag_q;
        for (int i = 0; i < N_KEYS; i++) begin
            gpio_in[cnt_lsb(i) +: PCNT_W] = pcnt_q[i];
        end
        gpio_in[RSVD_LSB +: RSVD_W]     = '0;
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_key_input_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_n = 4'h0;
    logic [3:0]  ack = 4'h0;
    logic [31:0] gpio_in;
    logic [3:0]  press_pulse;

    int total = 0;
    int bad   = 0;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .ack        (ack),
        .gpio_in    (gpio_in),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset asserted mid-cycle with all keys held down
        #23;
        rst = 1'b1;
        #1;
        chk("rst_gpio", gpio_in, 32'h0);
        chk("rst_pulse", {28'h0, press_pulse}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("rst_rel_early", gpio_in, 32'h0);
        tick(1);
        chk("rst_rel_gpio", gpio_in, 32'h001111FF);
        chk("rst_rel_pulse", {28'h0, press_pulse}, 32'hF);
        tick(1);
        chk("rst_rel_pulse_off", {28'h0, press_pulse}, 32'h0);
        key_n = 4'hF;
        tick(6);
        chk("rst_rel_release", gpio_in, 32'h001111F0);

        // Reset in the middle of a debounce discards the partial count
        key_n = 4'hE;
        tick(4);
        rst = 1'b1;
        #1;
        chk("mid_rst_gpio", gpio_in, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("mid_rst_early", gpio_in, 32'h0);
        tick(1);
        chk("mid_rst_accept", gpio_in, 32'h00000111);
        chk("mid_rst_pulse", {28'h0, press_pulse}, 32'h1);
        key_n = 4'hF;
        tick(6);
        chk("mid_rst_release", gpio_in, 32'h00000110);

        // Clean press on key1
        key_n = 4'hD;
        tick(5);
        chk("k1_early", gpio_in, 32'h00000110);
        chk("k1_early_pulse", {28'h0, press_pulse}, 32'h0);
        tick(1);
        chk("k1_accept", gpio_in, 32'h00001132);
        chk("k1_pulse", {28'h0, press_pulse}, 32'h2);
        tick(1);
        chk("k1_pulse_off", {28'h0, press_pulse}, 32'h0);
        key_n = 4'hF;
        tick(5);
        chk("k1_rel_early", gpio_in, 32'h00001132);
        tick(1);
        chk("k1_rel", gpio_in, 32'h00001130);
        chk("k1_rel_pulse", {28'h0, press_pulse}, 32'h0);

        ack = 4'hF;
        tick(1);
        ack = 4'h0;
        chk("ack_all", gpio_in, 32'h00001100);

        // Bounce on key0: low 3, high 1, then held low
        key_n = 4'hE;
        tick(3);
        chk("bnc_a", gpio_in, 32'h00001100);
        key_n = 4'hF;
        tick(1);
        key_n = 4'hE;
        tick(3);
        chk("bnc_b", gpio_in, 32'h00001100);
        chk("bnc_b_pulse", {28'h0, press_pulse}, 32'h0);
        tick(2);
        chk("bnc_hold_early", gpio_in, 32'h00001100);
        tick(1);
        chk("bnc_accept", gpio_in, 32'h00001211);
        chk("bnc_pulse", {28'h0, press_pulse}, 32'h1);
        key_n = 4'hF;
        tick(6);
        chk("bnc_release", gpio_in, 32'h00001210);

        // Ack racing a new press on key2
        key_n = 4'hB;
        tick(6);
        chk("k2_first", gpio_in, 32'h00011254);
        key_n = 4'hF;
        tick(6);
        chk("k2_first_rel", gpio_in, 32'h00011250);
        key_n = 4'hB;
        tick(5);
        ack = 4'h4;
        tick(1);
        chk("race_set_wins", gpio_in, 32'h00021254);
        tick(1);
        ack = 4'h0;
        chk("race_ack_clear", gpio_in, 32'h00021214);
        key_n = 4'hF;
        tick(6);
        chk("race_release", gpio_in, 32'h00021210);

        // Counter wrap on key3 from a clean reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("wrap_rst", gpio_in, 32'h0);
        for (int p = 1; p <= 16; p++) begin
            key_n = 4'h7;
            tick(6);
            if (p == 15) chk("wrap_15", {28'h0, gpio_in[23:20]}, 32'hF);
            if (p == 16) chk("wrap_16", {28'h0, gpio_in[23:20]}, 32'h0);
            chk("wrap_rsvd", {24'h0, gpio_in[31:24]}, 32'h0);
            key_n = 4'hF;
            tick(6);
        end
        chk("wrap_final", gpio_in, 32'h00000080);

        // All four keys pressed together
        ack = 4'hF;
        tick(1);
        ack = 4'h0;
        chk("conc_cleared", gpio_in, 32'h0);
        key_n = 4'h0;
        tick(5);
        chk("conc_early_pulse", {28'h0, press_pulse}, 32'h0);
        tick(1);
        chk("conc_pulse", {28'h0, press_pulse}, 32'hF);
        chk("conc_gpio", gpio_in, 32'h001111FF);
        tick(1);
        chk("conc_pulse_off", {28'h0, press_pulse}, 32'h0);
        key_n = 4'hF;
        tick(6);
        chk("conc_release", gpio_in, 32'h001111F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
